// File: rtl/ahb_uart_tx_pkg.sv
// Shared constants and types for the AHB console transmitter.
package ahb_uart_tx_pkg;

    // Register offsets as seen on haddr[3:2]
    localparam logic [1:0]  UART_TXDATA_OFS = 2'd0;
    localparam logic [1:0]  UART_STATUS_OFS = 2'd1;
    localparam logic [1:0]  UART_DIV_OFS    = 2'd2;

    // 32 MHz system clock / 115200 baud - 1
    localparam logic [15:0] UART_DIV_RST    = 16'd277;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/ahb_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is only
// taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ahb_uart_tx.sv
// AHB-Lite console transmitter: bus writes feed a TX FIFO drained by an
// 8N1 serializer.
//
//  state | meaning
//  IDLE  | line high, waiting for a byte in the FIFO
//  START | start bit (line low) for one bit time
//  DATA  | 8 data bits, LSB first
//  STOP  | stop bit (line high); chains straight into START if more data
module ahb_uart_tx
    import ahb_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RST    = UART_DIV_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hresp,
    output logic        hready_out,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus data-phase state
    logic           wr_q;
    logic           rd_q;
    logic [1:0]     ofs_q;
    logic [15:0]    div_q;

    // Serializer state
    uart_tx_state_e state_q;
    logic [15:0]    cnt_q;
    logic [15:0]    div_lat_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shreg_q;
    logic           tx_q;

    logic           addr_accept;
    logic           txdata_wr;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           busy;
    logic           unused_ok;

    assign addr_accept = hsel & htrans[1] & hready_in;
    assign txdata_wr   = wr_q & (ofs_q == UART_TXDATA_OFS);
    assign busy        = (state_q != IDLE);

    // A serializer pop in the same cycle frees the slot, so a full FIFO
    // does not stall the write in that cycle.
    assign fifo_pop    = ~fifo_empty &
                         ((state_q == IDLE) || ((state_q == STOP) && (cnt_q == 16'd0)));
    assign fifo_push   = txdata_wr & (~fifo_full | fifo_pop);
    assign hready_out  = ~(txdata_wr & fifo_full & ~fifo_pop);

    assign hresp       = 1'b0;
    assign uart_tx     = tx_q;
    assign irq         = fifo_empty & ~busy;

    // Only haddr[3:2] and the low data bits matter; every access is a word
    assign unused_ok   = ^{hsize, haddr[31:4], haddr[1:0], hwdata[31:16], htrans[0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (hwdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Capture the address phase; held while a TXDATA write is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            ofs_q <= 2'd0;
        end else if (hready_out) begin
            wr_q  <= addr_accept & hwrite;
            rd_q  <= addr_accept & ~hwrite;
            ofs_q <= haddr[3:2];
        end
    end

    // Baud divisor register; the serializer samples it at each START
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_RST;
        end else if (wr_q && (ofs_q == UART_DIV_OFS)) begin
            div_q <= hwdata[15:0];
        end
    end

    // Zero-wait read mux driven from the registered offset
    always_comb begin
        hrdata = '0;
        if (rd_q) begin
            case (ofs_q)
                UART_STATUS_OFS: begin
                    hrdata[0]    = fifo_full;
                    hrdata[1]    = fifo_empty;
                    hrdata[2]    = busy;
                    hrdata[15:8] = 8'(fifo_count);
                end
                UART_DIV_OFS: hrdata[15:0] = div_q;
                default:      hrdata = '0;
            endcase
        end
    end

    // 8N1 serializer; every bit lasts div_lat_q+1 cycles via a down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            div_lat_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        shreg_q   <= fifo_dout;
                        div_lat_q <= div_q;
                        cnt_q     <= div_q;
                        tx_q      <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q     <= div_lat_q;
                        bit_idx_q <= 3'd0;
                        tx_q      <= shreg_q[0];
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_lat_q;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (fifo_pop) begin
                            shreg_q   <= fifo_dout;
                            div_lat_q <= div_q;
                            cnt_q     <= div_q;
                            tx_q      <= 1'b0;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
